// File: rtl/spi.sv
// spi: memory-mapped SPI master, mode 0, MSB first, 8-bit frames.
// Build option SPI_IRQ_EN adds the level interrupt output spi_irpt (rx_valid & ie).

module spi #(
    parameter logic [15:0] DIV_RESET = 16'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_valid,
    input  logic        spi_instr,
    input  logic [31:0] spi_addr,
    input  logic [31:0] spi_wdata,
    input  logic [3:0]  spi_wstrb,
    output logic [31:0] spi_rdata,
    output logic        spi_ready,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
`ifdef SPI_IRQ_EN
    ,
    output logic        spi_irpt
`endif
);

    // state | meaning
    // IDLE  | no transfer in progress, sclk low
    // LOW   | sclk low half-period, mosi holds the current bit
    // HIGH  | sclk high half-period, miso bit already captured
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bits;
    logic [7:0]  shreg;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] ctrl_div;
    logic        ctrl_cs;
    logic        ctrl_ie;
    logic [1:0]  miso_sync;

    logic        accept;
    logic        is_write;
    logic [1:0]  reg_sel;
    logic        busy;
    logic        tc;
    logic        done;
    logic        data_rd;
    logic        data_wr;
    logic        ctrl_wr;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign accept   = spi_valid & ~spi_ready;
    assign is_write = |spi_wstrb;
    assign reg_sel  = spi_addr[3:2];
    assign busy     = (state != IDLE);
    assign tc       = (cnt == 16'd0);
    assign done     = (state == HIGH) && tc && (bits == 3'd7);
    assign data_rd  = accept && !is_write && (reg_sel == REG_DATA);
    assign data_wr  = accept && is_write && (reg_sel == REG_DATA);
    assign ctrl_wr  = accept && is_write && (reg_sel == REG_CTRL);
    assign spi_cs_n = ~ctrl_cs;

    assign unused_bits = ^{spi_instr, spi_addr[31:4], spi_addr[1:0], spi_wdata[31:18]};

    // A DATA read landing on the completion cycle must see the byte being retired.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DATA:   rd_mux[7:0]  = done ? shreg : rx_data;
            REG_STATUS: rd_mux[1:0]  = {rx_valid, busy};
            REG_CTRL:   rd_mux[17:0] = {ctrl_ie, ctrl_cs, ctrl_div};
            default:    rd_mux       = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso_sync <= 2'b00;
        end else begin
            miso_sync <= {miso_sync[0], spi_miso};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spi_ready <= 1'b0;
            spi_rdata <= '0;
            ctrl_div  <= DIV_RESET;
            ctrl_cs   <= 1'b0;
            ctrl_ie   <= 1'b0;
        end else begin
            spi_ready <= accept;
            spi_rdata <= (accept && !is_write) ? rd_mux : '0;
            if (ctrl_wr) begin
                if (spi_wstrb[0]) ctrl_div[7:0]  <= spi_wdata[7:0];
                if (spi_wstrb[1]) ctrl_div[15:8] <= spi_wdata[15:8];
                if (spi_wstrb[2]) begin
                    ctrl_cs <= spi_wdata[16];
                    ctrl_ie <= spi_wdata[17];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (done) begin
            rx_data  <= shreg;
            rx_valid <= ~data_rd;
        end else if (data_rd) begin
            rx_valid <= 1'b0;
        end
    end

    // cnt is a down-counter reloaded from div at every half-period boundary,
    // so a div change mid-transfer applies from the next half-period.
    // The shift register takes miso on the rising edge; its MSB is then the next tx bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bits     <= 3'd0;
            shreg    <= 8'h00;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_wr) begin
                        state    <= LOW;
                        shreg    <= spi_wdata[7:0];
                        spi_mosi <= spi_wdata[7];
                        cnt      <= ctrl_div;
                        bits     <= 3'd0;
                        spi_sclk <= 1'b0;
                    end
                end
                LOW: begin
                    if (tc) begin
                        state    <= HIGH;
                        spi_sclk <= 1'b1;
                        shreg    <= {shreg[6:0], miso_sync[1]};
                        cnt      <= ctrl_div;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        spi_sclk <= 1'b0;
                        cnt      <= ctrl_div;
                        if (bits == 3'd7) begin
                            state <= IDLE;
                        end else begin
                            state    <= LOW;
                            bits     <= bits + 3'd1;
                            spi_mosi <= shreg[7];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    spi_sclk <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spi_irpt <= 1'b0;
        end else begin
            spi_irpt <= rx_valid & ctrl_ie;
        end
    end
`endif

endmodule

// File: tb/tb_spi.sv
// tb_spi: randomized self-checking bench for the spi master against a timing/byte model.
// Compile with SPI_IRQ_EN defined to include the interrupt checks.

module tb_spi;

    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;
    localparam logic [31:0] A_RSV  = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_valid = 1'b0;
    logic        spi_instr = 1'b0;
    logic [31:0] spi_addr = '0;
    logic [31:0] spi_wdata = '0;
    logic [3:0]  spi_wstrb = '0;
    logic [31:0] spi_rdata;
    logic        spi_ready;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;
`ifdef SPI_IRQ_EN
    logic        spi_irpt;
`endif

    spi dut (
        .clk       (clk),
        .rst       (rst),
        .spi_valid (spi_valid),
        .spi_instr (spi_instr),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_wstrb (spi_wstrb),
        .spi_rdata (spi_rdata),
        .spi_ready (spi_ready),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n)
`ifdef SPI_IRQ_EN
        ,
        .spi_irpt  (spi_irpt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [7:0] last_rx = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: loopback of mosi, or a fixed byte shifted out MSB first.
    bit         loopback = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    int         nrise = 0;
    logic       slave_bit;
    assign slave_bit = (nrise < 8) ? slave_byte[3'(7 - nrise)] : 1'b0;
    assign spi_miso  = loopback ? spi_mosi : slave_bit;

    logic sclk_prev = 1'b0;
    int   rise_q[$];
    int   fall_q[$];
    bit   mosi_q[$];

    always @(negedge clk) begin
        if (spi_sclk && !sclk_prev) begin
            rise_q.push_back(cyc);
            mosi_q.push_back(spi_mosi);
            nrise = nrise + 1;
        end
        if (!spi_sclk && sclk_prev) fall_q.push_back(cyc);
        sclk_prev = spi_sclk;
    end

    task automatic clear_mon();
        rise_q.delete();
        fall_q.delete();
        mosi_q.delete();
        nrise = 0;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        while (spi_ready) @(negedge clk);
        spi_valid = 1'b1;
        spi_addr  = a;
        spi_wdata = wd;
        spi_wstrb = ws;
        lat = 0;
        rd  = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (spi_ready) begin
                rd = spi_rdata;
                break;
            end
        end
        acc_cyc   = cyc;
        spi_valid = 1'b0;
        spi_wstrb = '0;
    endtask

    task automatic wait_transfer(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fall_q.size() >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        rst = 1'b1;
        #3 rst = 1'b0;
        #10;
        checks++; if (spi_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", spi_ready); end
        checks++; if (spi_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", spi_rdata); end
        checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", spi_mosi); end
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", spi_cs_n); end
`ifdef SPI_IRQ_EN
        checks++; if (spi_irpt !== 1'b0) begin failures++; $display("FAIL rst_irpt got=%b exp=0", spi_irpt); end
`endif
        @(negedge clk);
        rst = 1'b1;
        bus(A_CTRL, 32'h0, 4'h0, rd, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL rst_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 32'h0000_0003) begin failures++; $display("FAIL rst_ctrl got=%h exp=00000003", rd); end
        bus(A_STAT, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_status got=%h exp=0", rd); end
        bus(A_DATA, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", rd); end
        bus(A_RSV, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_rsv got=%h exp=0", rd); end
    endtask

    task automatic test_ctrl_regs();
        logic [31:0] rd, wd, a;
        logic [3:0]  ws;
        logic [17:0] cm;
        int lat;
        cm = 18'd3;
        for (int n = 0; n < 6; n++) begin
            wd = $urandom;
            ws = 4'($urandom);
            a  = $urandom;
            a[3:0] = 4'h8;
            if (ws[0]) cm[7:0]   = wd[7:0];
            if (ws[1]) cm[15:8]  = wd[15:8];
            if (ws[2]) cm[17:16] = wd[17:16];
            bus(a, wd, ws, rd, lat);
            bus(A_CTRL, 32'h0, 4'h0, rd, lat);
            checks++; if (rd !== {14'h0, cm}) begin failures++; $display("FAIL ctrl_rw got=%h exp=%h", rd, {14'h0, cm}); end
            checks++; if (spi_cs_n !== ~cm[16]) begin failures++; $display("FAIL ctrl_cs_n got=%b exp=%b", spi_cs_n, ~cm[16]); end
        end
        bus(A_STAT, 32'hFFFF_FFFF, 4'hF, rd, lat);
        bus(A_RSV, 32'hFFFF_FFFF, 4'hF, rd, lat);
        bus(A_STAT, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL status_wr_ignored got=%h exp=0", rd); end
        bus(A_RSV, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rsv_read got=%h exp=0", rd); end
    endtask

    task automatic test_transfer();
        logic [31:0] rd;
        logic [7:0]  tx;
        int lat, d, e0;
        bit ok;
        loopback = 1'b1;
        for (int n = 0; n < 3; n++) begin
            d  = (n == 0) ? 2 : int'($urandom_range(4, 2));
            tx = (n == 0) ? 8'hA5 : 8'($urandom);
            bus(A_CTRL, 32'h0001_0000 | 32'(d), 4'hF, rd, lat);
            checks++; if (spi_cs_n !== 1'b0) begin failures++; $display("FAIL xfer_cs_n got=%b exp=0", spi_cs_n); end
            clear_mon();
            bus(A_DATA, {24'h0, tx}, 4'h1, rd, lat);
            e0 = acc_cyc;
            checks++; if (lat !== 1) begin failures++; $display("FAIL xfer_wr_lat got=%0d exp=1", lat); end
            bus(A_STAT, 32'h0, 4'h0, rd, lat);
            checks++; if (rd !== 32'h1) begin failures++; $display("FAIL xfer_busy got=%h exp=1", rd); end
            wait_transfer(ok);
            checks++; if (!ok) begin failures++; $display("FAIL xfer_timeout got=%0d exp=8 falls", fall_q.size()); end
            checks++; if (rise_q.size() !== 8) begin failures++; $display("FAIL xfer_nrise got=%0d exp=8", rise_q.size()); end
            for (int i = 0; i < 8 && i < rise_q.size() && i < fall_q.size(); i++) begin
                checks++;
                if (rise_q[i] - e0 !== (2 * i + 1) * (d + 1)) begin
                    failures++; $display("FAIL xfer_rise%0d got=%0d exp=%0d", i, rise_q[i] - e0, (2 * i + 1) * (d + 1));
                end
                checks++;
                if (fall_q[i] - e0 !== (2 * i + 2) * (d + 1)) begin
                    failures++; $display("FAIL xfer_fall%0d got=%0d exp=%0d", i, fall_q[i] - e0, (2 * i + 2) * (d + 1));
                end
                checks++;
                if (mosi_q[i] !== tx[3'(7 - i)]) begin
                    failures++; $display("FAIL xfer_mosi%0d got=%b exp=%b", i, mosi_q[i], tx[3'(7 - i)]);
                end
            end
            bus(A_STAT, 32'h0, 4'h0, rd, lat);
            checks++; if (rd !== 32'h2) begin failures++; $display("FAIL xfer_rxvalid got=%h exp=2", rd); end
            bus(A_DATA, 32'h0, 4'h0, rd, lat);
            checks++; if (rd !== {24'h0, tx}) begin failures++; $display("FAIL xfer_rx got=%h exp=%h", rd, {24'h0, tx}); end
            last_rx = tx;
            bus(A_STAT, 32'h0, 4'h0, rd, lat);
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL xfer_status_after got=%h exp=0", rd); end
        end
    endtask

    task automatic test_write_while_busy();
        logic [31:0] rd;
        logic [7:0]  tx;
        int lat;
        bit ok;
        loopback = 1'b1;
        tx = 8'($urandom);
        if (tx == 8'h3C) tx = 8'hC3;
        bus(A_CTRL, 32'h0001_0002, 4'hF, rd, lat);
        clear_mon();
        bus(A_DATA, {24'h0, tx}, 4'h1, rd, lat);
        bus(A_DATA, 32'h0000_003C, 4'h1, rd, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL busy_wr_lat got=%0d exp=1", lat); end
        wait_transfer(ok);
        checks++; if (!ok || rise_q.size() !== 8) begin failures++; $display("FAIL busy_wr_nrise got=%0d exp=8", rise_q.size()); end
        for (int i = 0; i < 8 && i < mosi_q.size(); i++) begin
            checks++;
            if (mosi_q[i] !== tx[3'(7 - i)]) begin
                failures++; $display("FAIL busy_wr_mosi%0d got=%b exp=%b", i, mosi_q[i], tx[3'(7 - i)]);
            end
        end
        bus(A_DATA, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== {24'h0, tx}) begin failures++; $display("FAIL busy_wr_rx got=%h exp=%h", rd, {24'h0, tx}); end
        last_rx = tx;
    endtask

    task automatic test_overwrite();
        logic [31:0] rd;
        logic [7:0]  t1, t2;
        int lat;
        bit ok;
        loopback = 1'b1;
        t1 = 8'($urandom);
        t2 = t1 ^ 8'($urandom_range(255, 1));
        clear_mon();
        bus(A_DATA, {24'h0, t1}, 4'h1, rd, lat);
        wait_transfer(ok);
        clear_mon();
        bus(A_DATA, {24'h0, t2}, 4'h1, rd, lat);
        wait_transfer(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovw_timeout got=%0d exp=8 falls", fall_q.size()); end
        bus(A_STAT, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h2) begin failures++; $display("FAIL ovw_status got=%h exp=2", rd); end
        bus(A_DATA, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== {24'h0, t2}) begin failures++; $display("FAIL ovw_rx got=%h exp=%h", rd, {24'h0, t2}); end
        last_rx = t2;
    endtask

    task automatic test_back_to_back();
        bit p[4];
        bit exp_p[4];
        logic [31:0] rd_seen;
        exp_p = '{1'b0, 1'b1, 1'b0, 1'b1};
        rd_seen = 32'hFFFF_FFFF;
        @(negedge clk);
        while (spi_ready) @(negedge clk);
        spi_addr  = A_STAT;
        spi_wstrb = 4'h0;
        spi_valid = 1'b1;
        p[0] = spi_ready;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            p[k] = spi_ready;
            if (spi_ready) rd_seen = spi_rdata;
        end
        spi_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (p[k] !== exp_p[k]) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, p[k], exp_p[k]); end
        end
        checks++; if (rd_seen !== 32'h0) begin failures++; $display("FAIL b2b_rdata got=%h exp=0", rd_seen); end
    endtask

    task automatic test_coincident_read();
        logic [31:0] rd;
        logic [7:0]  tx;
        int lat, d, target;
        loopback   = 1'b0;
        slave_byte = 8'($urandom);
        if (slave_byte == last_rx) slave_byte = slave_byte ^ 8'h01;
        tx = 8'($urandom);
        d  = int'($urandom_range(4, 2));
        bus(A_CTRL, 32'h0001_0000 | 32'(d), 4'hF, rd, lat);
        clear_mon();
        bus(A_DATA, {24'h0, tx}, 4'h1, rd, lat);
        target = acc_cyc + 16 * (d + 1);
        for (int i = 0; i < 200 && cyc < target - 1; i++) begin
            @(posedge clk);
            #1;
        end
        bus(A_DATA, 32'h0, 4'h0, rd, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL coinc_lat got=%0d exp=1", lat); end
        checks++; if (rd !== {24'h0, slave_byte}) begin failures++; $display("FAIL coinc_rx got=%h exp=%h", rd, {24'h0, slave_byte}); end
        bus(A_STAT, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL coinc_status got=%h exp=0", rd); end
        last_rx  = slave_byte;
        loopback = 1'b1;
    endtask

`ifdef SPI_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        int lat;
        bit ok;
        loopback = 1'b1;
        bus(A_CTRL, 32'h0003_0002, 4'hF, rd, lat);
        clear_mon();
        bus(A_DATA, 32'h0000_0096, 4'h1, rd, lat);
        checks++; if (spi_irpt !== 1'b0) begin failures++; $display("FAIL irq_busy got=%b exp=0", spi_irpt); end
        wait_transfer(ok);
        repeat (2) @(negedge clk);
        checks++; if (spi_irpt !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", spi_irpt); end
        bus(A_DATA, 32'h0, 4'h0, rd, lat);
        repeat (2) @(negedge clk);
        checks++; if (spi_irpt !== 1'b0) begin failures++; $display("FAIL irq_clr_read got=%b exp=0", spi_irpt); end
        clear_mon();
        bus(A_DATA, 32'h0000_0011, 4'h1, rd, lat);
        wait_transfer(ok);
        repeat (2) @(negedge clk);
        checks++; if (spi_irpt !== 1'b1) begin failures++; $display("FAIL irq_set2 got=%b exp=1", spi_irpt); end
        bus(A_CTRL, 32'h0001_0002, 4'hF, rd, lat);
        repeat (2) @(negedge clk);
        checks++; if (spi_irpt !== 1'b0) begin failures++; $display("FAIL irq_clr_ie got=%b exp=0", spi_irpt); end
        bus(A_DATA, 32'h0, 4'h0, rd, lat);
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        bit seen;
        loopback = 1'b1;
        bus(A_CTRL, 32'h0001_0002, 4'hF, rd, lat);
        clear_mon();
        bus(A_DATA, 32'h0000_00F0, 4'h1, rd, lat);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_sclk) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL rmid_sclk_high got=0 exp=1"); end
        rst = 1'b0;
        #1;
        checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL rmid_sclk got=%b exp=0", spi_sclk); end
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL rmid_cs_n got=%b exp=1", spi_cs_n); end
        @(negedge clk);
        rst = 1'b1;
        bus(A_STAT, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_status got=%h exp=0", rd); end
        bus(A_CTRL, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h3) begin failures++; $display("FAIL rmid_ctrl got=%h exp=3", rd); end
    endtask

    initial begin
        test_reset();
        test_ctrl_regs();
        test_transfer();
        test_write_while_busy();
        test_overwrite();
        test_back_to_back();
        test_coincident_read();
`ifdef SPI_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
